// File: rtl/gshare_bht.sv
// gshare_bht: gshare branch history table for the fetch frontend.
//
// The table holds INSTR_PER_FETCH columns of CTR_BITS-wide saturating counters.
// Each counter has a valid bit. The row is the fetch PC hashed (XOR) with a
// global history register. After reset or flush, the table is rewritten one
// row per cycle. During that time busy_o is high and every prediction is
// suppressed.
//
// Ports:
//   clk_i, rst_ni         clock (rising edge), synchronous active-low reset
//   flush_bp_i            restart table initialisation from row 0, clear GHR
//   debug_mode_i          drop updates while in debug mode
//   vpc_i                 fetch PC; prediction appears one cycle later
//   pred_valid_o/taken_o  per-column prediction (registered)
//   pred_index_o          hashed row used for the prediction (update metadata)
//   busy_o                table initialisation in progress
//   upd_valid_i/pc_i/taken_i/index_i  resolved-branch update
module gshare_bht #(
  parameter int unsigned VLEN            = 64,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned CTR_BITS        = 2,
  parameter int unsigned HIST_BITS       = 8,
  parameter int unsigned INSTR_ALIGN     = 1,
  localparam int unsigned NR_ROWS       = NR_ENTRIES / INSTR_PER_FETCH,
  localparam int unsigned ROW_BITS      = $clog2(NR_ROWS)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_bp_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
  output logic [ROW_BITS-1:0]        pred_index_o,
  output logic                       busy_o,
  input  logic                       upd_valid_i,
  input  logic [VLEN-1:0]            upd_pc_i,
  input  logic                       upd_taken_i,
  input  logic [ROW_BITS-1:0]        upd_index_i
);

  localparam int unsigned COL_BITS = $clog2(INSTR_PER_FETCH);
  // Keeps the column slice legal when there is only one column.
  localparam int unsigned COL_W    = (COL_BITS == 0) ? 1 : COL_BITS;

  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(NR_ROWS - 1);

  typedef enum logic {StInit, StIdle} state_e;

  state_e                     r_state;
  logic [ROW_BITS-1:0]        r_init_row;
  logic [HIST_BITS-1:0]       r_ghr;
  logic [ROW_BITS-1:0]        r_pred_idx;
  logic [INSTR_PER_FETCH-1:0] r_pred_valid;
  logic [INSTR_PER_FETCH-1:0] r_pred_taken;

  // Table storage (no reset: contents are rebuilt by the init walk).
  logic [CTR_BITS-1:0] r_ctr [NR_ROWS][INSTR_PER_FETCH];
  logic                r_vld [NR_ROWS][INSTR_PER_FETCH];

  logic [ROW_BITS-1:0] w_pred_row;
  logic [COL_W-1:0]    w_upd_col;
  logic [CTR_BITS-1:0] w_upd_old;
  logic [CTR_BITS-1:0] w_upd_new;
  logic                w_upd_en;
  logic                w_init_wr;
  logic                w_unused;

  assign w_pred_row = vpc_i[INSTR_ALIGN+COL_BITS +: ROW_BITS] ^ ROW_BITS'(r_ghr);
  assign w_upd_col  = upd_pc_i[INSTR_ALIGN +: COL_W] & COL_W'(INSTR_PER_FETCH - 1);

  // Flush beats a same-cycle update; updates outside IDLE are dropped.
  assign w_upd_en  = rst_ni && (r_state == StIdle) && upd_valid_i && !debug_mode_i &&
                     !flush_bp_i;
  // A flush during INIT restarts the walk without writing the current row.
  assign w_init_wr = rst_ni && (r_state == StInit) && !flush_bp_i;

  assign w_upd_old = r_ctr[upd_index_i][w_upd_col];

  always_comb begin
    w_upd_new = w_upd_old;
    if (upd_taken_i) begin
      if (w_upd_old != CTR_MAX) w_upd_new = w_upd_old + CTR_BITS'(1);
    end else begin
      if (w_upd_old != '0) w_upd_new = w_upd_old - CTR_BITS'(1);
    end
  end

  // Control FSM, GHR and registered prediction outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= StInit;
      r_init_row   <= '0;
      r_ghr        <= '0;
      r_pred_idx   <= '0;
      r_pred_valid <= '0;
      r_pred_taken <= '0;
    end else begin
      // Read-first: a same-edge update is not visible in this prediction.
      r_pred_idx <= w_pred_row;
      for (int c = 0; c < INSTR_PER_FETCH; c++) begin
        r_pred_valid[c] <= (r_state == StIdle) && r_vld[w_pred_row][c];
        r_pred_taken[c] <= (r_state == StIdle) && r_ctr[w_pred_row][c][CTR_BITS-1];
      end

      unique case (r_state)
        StInit: begin
          if (flush_bp_i) begin
            r_init_row <= '0;
          end else if (r_init_row == ROW_LAST) begin
            r_init_row <= '0;
            r_state    <= StIdle;
          end else begin
            r_init_row <= r_init_row + ROW_BITS'(1);
          end
        end
        StIdle: begin
          if (flush_bp_i) begin
            r_state    <= StInit;
            r_init_row <= '0;
            r_ghr      <= '0;
          end else if (w_upd_en) begin
            r_ghr <= (r_ghr << 1) | HIST_BITS'(upd_taken_i);
          end
        end
        default: r_state <= StInit;
      endcase
    end
  end

  // Table write port: either a full init row or a single updated entry.
  always_ff @(posedge clk_i) begin
    if (w_init_wr) begin
      for (int c = 0; c < INSTR_PER_FETCH; c++) begin
        r_ctr[r_init_row][c] <= CTR_INIT;
        r_vld[r_init_row][c] <= 1'b0;
      end
    end else if (w_upd_en) begin
      r_ctr[upd_index_i][w_upd_col] <= w_upd_new;
      r_vld[upd_index_i][w_upd_col] <= 1'b1;
    end
  end

  assign pred_index_o = r_pred_idx;
  assign pred_valid_o = r_pred_valid;
  assign pred_taken_o = r_pred_taken;
  assign busy_o       = (r_state == StInit);

  // Only a slice of each PC feeds the table.
  assign w_unused = ^{vpc_i, upd_pc_i};

endmodule
